// File: rtl/dec_stream_out.sv
// dec_stream_out: drains one bank of the ping-pong decision RAM as a valid/ready stream.
//   clk, rst_n            clock, asynchronous active-low reset
//   start, bank_sel       frame-ready pulse and the bank it refers to
//   busy, done            frame in progress, one-cycle end-of-frame pulse
//   dec_address, dec_cs,
//   dec_we                decision RAM read port (one chip select per bank, never writes)
//   dec_data_out_0/1      RAM read data, valid the cycle after the read is issued
//   out_data, out_valid,
//   out_ready, out_last   output stream; out_last marks the final word of the frame
module dec_stream_out #(
    parameter int DECISION_WIDTH = 1,
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int FRAME_LEN      = RAM_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      bank_sel,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH-1:0]     dec_address,
    output logic [1:0]                dec_cs,
    output logic [1:0]                dec_we,
    input  logic [DECISION_WIDTH-1:0] dec_data_out_0,
    input  logic [DECISION_WIDTH-1:0] dec_data_out_1,
    output logic [DECISION_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);
    localparam int LEN = (FRAME_LEN > RAM_DEPTH) ? RAM_DEPTH : FRAME_LEN;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(LEN - 1);
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                    state_q;
    logic                      rbank_q;
    logic [ADDR_WIDTH:0]       rd_addr_q;
    logic [ADDR_WIDTH:0]       idx_q;
    logic                      inflight_q;
    logic [DECISION_WIDTH-1:0] mem_q [2];
    logic                      wr_ptr_q;
    logic                      rd_ptr_q;
    logic [1:0]                count_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      last_pop_q;

    logic                      pop;
    logic                      issue;
    logic                      accept;
    logic [DECISION_WIDTH-1:0] rdata;

    assign out_valid   = count_q != 2'd0;
    assign pop         = out_valid & out_ready;
    // Credit check: words already owed to the FIFO must leave room for this read.
    assign issue       = (state_q == READ) &&
                         (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    // A start coinciding with done belongs to the frame just finished and is dropped.
    assign accept      = (state_q == IDLE) && start && !done_q;
    assign rdata       = rbank_q ? dec_data_out_1 : dec_data_out_0;
    assign out_data    = mem_q[rd_ptr_q];
    assign out_last    = out_valid && (idx_q == LAST);
    assign dec_cs      = issue ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;
    assign dec_we      = 2'b00;
    assign dec_address = rd_addr_q[ADDR_WIDTH-1:0];
    assign busy        = busy_q;
    assign done        = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rbank_q    <= 1'b0;
            rd_addr_q  <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_pop_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            last_pop_q <= pop && out_last;
            inflight_q <= issue;
            count_q    <= count_q + {1'b0, inflight_q} - {1'b0, pop};
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                idx_q    <= idx_q + ONE;
            end
            if (issue)
                rd_addr_q <= rd_addr_q + ONE;
            case (state_q)
                IDLE: if (accept) begin
                    rbank_q   <= bank_sel;
                    rd_addr_q <= '0;
                    idx_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= READ;
                end
                READ: if (issue && rd_addr_q == LAST)
                    state_q <= DRAIN;
                DRAIN: if (last_pop_q) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dec_stream_out.sv
// tb_dec_stream_out: scoreboard bench for dec_stream_out (full-frame and single-word instances).
module tb_dec_stream_out;
    logic       clk = 1'b0;
    logic       rst_n, start, bank_sel, out_ready;
    logic       busy, done, out_valid, out_last;
    logic [7:0] dec_address;
    logic [1:0] dec_cs, dec_we;
    logic       rd0, rd1, out_data;

    logic       start2, ready2;
    logic       busy2, done2, valid2, last2, data2, d2_0;
    logic       d2_1 = 1'b0;
    logic [7:0] addr2;
    logic [1:0] cs2, we2;

    logic bank0 [256];
    logic bank1 [256];

    int checks = 0, errors = 0, cyc = 0;
    int words, issued, popped, first_hs, done_cnt = 0, done_cyc, start_cyc, done_base;
    int n2 = 0, hs2_cyc, done2_cnt = 0, done2_cyc;
    bit cs0_seen, cs1_seen;
    logic [1:0] sbq [$];
    logic [1:0] sb2 [$];
    logic [7:0] iss_addr [$];
    logic       hs;
    logic [1:0] e;

    dec_stream_out dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
        .busy(busy), .done(done), .dec_address(dec_address), .dec_cs(dec_cs), .dec_we(dec_we),
        .dec_data_out_0(rd0), .dec_data_out_1(rd1),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    dec_stream_out #(.FRAME_LEN(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bank_sel(1'b0),
        .busy(busy2), .done(done2), .dec_address(addr2), .dec_cs(cs2), .dec_we(we2),
        .dec_data_out_0(d2_0), .dec_data_out_1(d2_1),
        .out_data(data2), .out_valid(valid2), .out_ready(ready2), .out_last(last2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle synchronous-read RAM models.
    always @(posedge clk) begin
        if (dec_cs[0]) rd0 <= bank0[dec_address];
        if (dec_cs[1]) rd1 <= bank1[dec_address];
        if (cs2[0]) d2_0 <= (addr2 == 8'd0);
    end

    // Monitor: values seen at negedge are what the next posedge will sample.
    always @(negedge clk) if (rst_n) begin
        hs = out_valid && out_ready;
        checks++;
        if (dec_cs === 2'b11) begin errors++; $display("FAIL cs_onehot: got %b", dec_cs); end
        if (dec_cs[0]) cs0_seen = 1;
        if (dec_cs[1]) cs1_seen = 1;
        if (|dec_cs) begin
            checks++;
            if (issued - popped - int'(hs) >= 2) begin
                errors++; $display("FAIL credit: issue with outstanding %0d pop %0d", issued - popped, hs);
            end
            iss_addr.push_back(dec_address);
            issued++;
        end
        if (hs) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++; $display("FAIL unexpected_word: got %b%b", out_last, out_data);
            end else begin
                e = sbq.pop_front();
                if ({out_last, out_data} !== e) begin
                    errors++; $display("FAIL word%0d: got last/data %b%b want %b", words, out_last, out_data, e);
                end
            end
            if (words == 0) first_hs = cyc + 1;
            words++;
            popped++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (valid2 && ready2) begin
            checks++;
            if (sb2.size() == 0) begin
                errors++; $display("FAIL unexpected_word2: got %b%b", last2, data2);
            end else begin
                e = sb2.pop_front();
                if ({last2, data2} !== e) begin
                    errors++; $display("FAIL word2: got last/data %b%b want %b", last2, data2, e);
                end
            end
            hs2_cyc = cyc + 1;
            n2++;
        end
        if (done2) begin done2_cnt++; done2_cyc = cyc; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input bit b);
        logic [1:0] x;
        words = 0; issued = 0; popped = 0; cs0_seen = 0; cs1_seen = 0;
        iss_addr.delete();
        done_base = done_cnt;
        for (int i = 0; i < 256; i++) begin
            x = {i == 255, b ? bank1[i] : bank0[i]};
            sbq.push_back(x);
        end
        bank_sel = b;
        start = 1;
        start_cyc = cyc + 1;
        step();
        start = 0;
    endtask

    task automatic wait_done(input int bound, input bit rnd);
        for (int i = 0; i < bound && done_cnt == done_base; i++) begin
            if (rnd) out_ready = ($urandom_range(0, 9) < 3);
            step();
        end
        out_ready = 1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({busy, done, dec_cs, dec_we, dec_address, out_valid, out_last, out_data} !== 17'd0) begin
            errors++; $display("FAIL reset_values: got %b", {busy, done, dec_cs, dec_we, dec_address, out_valid, out_last, out_data});
        end
        rst_n = 1;
        step();
        checks++;
        if ({busy, done, dec_cs, out_valid, busy2, cs2, valid2} !== 9'd0) begin
            errors++; $display("FAIL idle_after_reset: got %b", {busy, done, dec_cs, out_valid, busy2, cs2, valid2});
        end
    endtask

    task automatic test_stream_bank0();
        begin_frame(0);
        wait_done(400, 0);
        checks++; if (done_cnt != done_base + 1) begin errors++; $display("FAIL b0_done_count: got %0d want %0d", done_cnt - done_base, 1); end
        checks++; if (words != 256) begin errors++; $display("FAIL b0_words: got %0d want 256", words); end
        checks++; if (first_hs != start_cyc + 3) begin errors++; $display("FAIL b0_first_hs: got %0d want %0d", first_hs, start_cyc + 3); end
        checks++; if (done_cyc != start_cyc + 259) begin errors++; $display("FAIL b0_done_cycle: got %0d want %0d", done_cyc, start_cyc + 259); end
        checks++; if (cs1_seen) begin errors++; $display("FAIL b0_cs1: got 1 want 0"); end
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL b0_left: got %0d want 0", sbq.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b0_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_bank1_restart();
        begin_frame(1);
        repeat (50) step();
        bank_sel = 0;
        start = 1;
        step();
        start = 0;
        wait_done(400, 0);
        checks++; if (done_cnt != done_base + 1) begin errors++; $display("FAIL b1_done_count: got %0d want 1", done_cnt - done_base); end
        checks++; if (words != 256) begin errors++; $display("FAIL b1_words: got %0d want 256", words); end
        checks++; if (cs0_seen) begin errors++; $display("FAIL b1_rbank: got cs0 want none"); end
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL b1_left: got %0d want 0", sbq.size()); end
    endtask

    task automatic test_backpressure();
        begin_frame(0);
        wait_done(3000, 1);
        checks++; if (done_cnt != done_base + 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - done_base); end
        checks++; if (words != 256) begin errors++; $display("FAIL bp_words: got %0d want 256", words); end
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL bp_left: got %0d want 0", sbq.size()); end
    endtask

    task automatic test_stall();
        out_ready = 0;
        begin_frame(1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 2) begin
                checks++;
                if ({out_valid, out_data, out_last} !== 3'b110) begin
                    errors++; $display("FAIL stall_head: got v/d/l %b%b%b want 110", out_valid, out_data, out_last);
                end
            end
        end
        checks++; if (issued != 2) begin errors++; $display("FAIL stall_reads: got %0d want 2", issued); end
        checks++;
        if (iss_addr.size() != 2 || iss_addr[0] !== 8'd0 || iss_addr[1] !== 8'd1) begin
            errors++; $display("FAIL stall_addrs: got n=%0d", iss_addr.size());
        end
        out_ready = 1;
        wait_done(400, 0);
        checks++; if (words != 256 || sbq.size() != 0) begin errors++; $display("FAIL stall_frame: got words %0d left %0d want 256 0", words, sbq.size()); end
    endtask

    task automatic test_reset_mid();
        int base;
        begin_frame(0);
        for (int i = 0; i < 300 && words < 100; i++) step();
        checks++; if (words != 100) begin errors++; $display("FAIL rm_reach: got %0d want 100", words); end
        base = done_cnt;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({busy, done, dec_cs, dec_we, dec_address, out_valid, out_last, out_data} !== 17'd0) begin
            errors++; $display("FAIL rm_async_values: got %b", {busy, done, dec_cs, dec_we, dec_address, out_valid, out_last, out_data});
        end
        sbq.delete();
        step();
        rst_n = 1;
        repeat (3) step();
        checks++; if (done_cnt != base || busy !== 1'b0) begin errors++; $display("FAIL rm_no_done: got done %0d busy %b want 0 0", done_cnt - base, busy); end
        begin_frame(1);
        wait_done(400, 0);
        checks++; if (iss_addr.size() == 0 || iss_addr[0] !== 8'd0) begin errors++; $display("FAIL rm_restart_addr: got n=%0d", iss_addr.size()); end
        checks++; if (words != 256 || sbq.size() != 0) begin errors++; $display("FAIL rm_frame: got words %0d left %0d want 256 0", words, sbq.size()); end
    endtask

    task automatic test_frame_len1();
        int s, base2;
        n2 = 0;
        base2 = done2_cnt;
        sb2.push_back(2'b11);
        start2 = 1;
        s = cyc + 1;
        step();
        start2 = 0;
        repeat (8) step();
        checks++; if (n2 != 1) begin errors++; $display("FAIL fl1_words: got %0d want 1", n2); end
        checks++; if (hs2_cyc != s + 3) begin errors++; $display("FAIL fl1_hs_cycle: got %0d want %0d", hs2_cyc, s + 3); end
        checks++; if (done2_cyc != s + 4 || done2_cnt != base2 + 1) begin errors++; $display("FAIL fl1_done: got cyc %0d want %0d", done2_cyc, s + 4); end
        sb2.push_back(2'b11);
        start2 = 1;
        step();
        start2 = 0;
        for (int i = 0; i < 20 && !done2; i++) step();
        checks++; if (!done2) begin errors++; $display("FAIL fl1_done_timeout: got 0 want 1"); end
        start2 = 1;
        step();
        start2 = 0;
        checks++; if (busy2 !== 1'b0 || cs2 !== 2'b00) begin errors++; $display("FAIL start_on_done: got busy %b cs %b want 0 00", busy2, cs2); end
        sb2.push_back(2'b11);
        start2 = 1;
        step();
        start2 = 0;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL start_after_done: got busy %b want 1", busy2); end
        repeat (8) step();
        checks++; if (sb2.size() != 0 || done2_cnt != base2 + 3) begin errors++; $display("FAIL fl1_tail: got left %0d done %0d want 0 3", sb2.size(), done2_cnt - base2); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            bank0[i] = i[0];
            bank1[i] = ~i[0];
        end
        rst_n = 0; start = 0; bank_sel = 0; out_ready = 1; start2 = 0; ready2 = 1;
        test_reset();
        test_stream_bank0();
        test_bank1_restart();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_frame_len1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
